// File: rtl/bird_wave_ctrl.sv
// bird_wave_ctrl: wave/level sequencer for the bird array.
// Runs a pause before each wave and then deploys one bird per slot, spaced
// by a frame gap. It waits for the wave to clear, then advances the level.
// All outputs are registered.
module bird_wave_ctrl #(
  parameter int NUM_OF_BIRDS       = 4,
  parameter int NUM_OF_LEVELS      = 4,
  parameter int DEPLOY_GAP_FRAMES  = 32,
  parameter int LEVEL_PAUSE_FRAMES = 120
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic                    enable,
  input  logic [7:0]              random_number,
  input  logic [NUM_OF_BIRDS-1:0] bird_alive,
  output logic [NUM_OF_BIRDS-1:0] deploy_bird,
  output logic [1:0]              bird_speed,
  output logic [3:0]              bird_life,
  output logic [1:0]              level,
  output logic                    wave_active,
  output logic                    game_won
);

  localparam int SW = (NUM_OF_BIRDS > 1) ? $clog2(NUM_OF_BIRDS) : 1;
  localparam logic [7:0]    PAUSE_LAST = 8'(LEVEL_PAUSE_FRAMES - 1);
  localparam logic [7:0]    GAP_BASE   = 8'(DEPLOY_GAP_FRAMES);
  localparam logic [1:0]    LAST_LEVEL = 2'(NUM_OF_LEVELS - 1);
  localparam logic [SW-1:0] LAST_SLOT  = SW'(NUM_OF_BIRDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE, S_DEPLOY, S_WAIT_CLEAR, S_WON
  } state_t;

  state_t                  r_state;
  logic [7:0]              r_frame_cnt;
  logic [7:0]              r_gap;
  logic [SW-1:0]           r_slot;
  logic                    r_armed;
  logic [NUM_OF_BIRDS-1:0] r_deploy;
  logic [1:0]              r_speed;
  logic [3:0]              r_life;
  logic [1:0]              r_level;
  logic                    r_wave_active;
  logic                    r_game_won;

  logic [7:0]              w_gap_next;
  logic                    w_due;
  logic                    w_slot_free;
  logic [1:0]              w_level_inc;
  logic                    w_unused_rand;

  // Only the low nibble of the LFSR jitters the gap.
  assign w_unused_rand = ^random_number[7:4];
  assign w_gap_next    = GAP_BASE + {4'b0, random_number[3:0]};
  assign w_due         = startOfFrame && (r_frame_cnt >= r_gap - 8'd1);
  assign w_slot_free   = ~bird_alive[r_slot];
  assign w_level_inc   = r_level + 2'd1;

  assign deploy_bird = r_deploy;
  assign bird_speed  = r_speed;
  assign bird_life   = r_life;
  assign level       = r_level;
  assign wave_active = r_wave_active;
  assign game_won    = r_game_won;

  // The speed code is the level clamped at 3. A 2-bit level never exceeds 3.
  function automatic logic [1:0] speed_of(input logic [1:0] l);
    return l;
  endfunction

  // The starting life is 2 + 2*level, clamped at 15.
  function automatic logic [3:0] life_of(input logic [1:0] l);
    logic [4:0] t;
    t = 5'd2 + {2'b0, l, 1'b0};
    return (t > 5'd15) ? 4'd15 : t[3:0];
  endfunction

  // Sequencer FSM. The frame counter is cleared on every state change, and
  // the deploy pulse defaults low so each pulse lasts exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_frame_cnt   <= 8'd0;
      r_gap         <= GAP_BASE;
      r_slot        <= '0;
      r_armed       <= 1'b0;
      r_deploy      <= '0;
      r_speed       <= 2'd0;
      r_life        <= 4'd2;
      r_level       <= 2'd0;
      r_wave_active <= 1'b0;
      r_game_won    <= 1'b0;
    end else begin
      r_deploy <= '0;
      if (startOfFrame && r_frame_cnt != 8'hFF)
        r_frame_cnt <= r_frame_cnt + 8'd1;

      if (!enable && r_state != S_WON) begin
        // Drop out of the game. The level is kept, and any due pulse is lost.
        r_state       <= S_IDLE;
        r_frame_cnt   <= 8'd0;
        r_wave_active <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state     <= S_PAUSE;
            r_frame_cnt <= 8'd0;
            r_speed     <= speed_of(r_level);
            r_life      <= life_of(r_level);
          end
          S_PAUSE: begin
            if (startOfFrame && r_frame_cnt == PAUSE_LAST) begin
              r_state       <= S_DEPLOY;
              r_frame_cnt   <= 8'd0;
              r_slot        <= '0;
              r_gap         <= GAP_BASE;
              r_wave_active <= 1'b1;
            end
          end
          S_DEPLOY: begin
            if (r_deploy[NUM_OF_BIRDS-1]) begin
              // The last slot's pulse is on the output, so this wave is fully deployed.
              r_state     <= S_WAIT_CLEAR;
              r_frame_cnt <= 8'd0;
              r_armed     <= 1'b0;
            end else if (w_due && w_slot_free) begin
              r_deploy    <= {{(NUM_OF_BIRDS-1){1'b0}}, 1'b1} << r_slot;
              r_slot      <= (r_slot == LAST_SLOT) ? '0 : r_slot + SW'(1);
              r_frame_cnt <= 8'd0;
              r_gap       <= w_gap_next;
            end
          end
          S_WAIT_CLEAR: begin
            // Skip the first frame, which gives the array time to raise its alive flags.
            if (startOfFrame) begin
              if (!r_armed) begin
                r_armed <= 1'b1;
              end else if (bird_alive == '0) begin
                r_frame_cnt   <= 8'd0;
                r_wave_active <= 1'b0;
                if (r_level != LAST_LEVEL) begin
                  r_state <= S_PAUSE;
                  r_level <= w_level_inc;
                  r_speed <= speed_of(w_level_inc);
                  r_life  <= life_of(w_level_inc);
                end else begin
                  r_state    <= S_WON;
                  r_game_won <= 1'b1;
                end
              end
            end
          end
          S_WON: begin
            r_state <= S_WON;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bird_wave_ctrl.sv
// Scoreboard bench for bird_wave_ctrl. The stimulus queues each expected
// deploy pulse, with its frame number and the wave settings. A forked
// monitor pops and checks each pulse when it appears.
module tb_bird_wave_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       enable;
  logic [7:0] random_number;
  logic [3:0] bird_alive;
  logic [3:0] deploy_bird;
  logic [1:0] bird_speed;
  logic [3:0] bird_life;
  logic [1:0] level;
  logic       wave_active;
  logic       game_won;

  always #5 clk = ~clk;

  bird_wave_ctrl dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
    .random_number(random_number), .bird_alive(bird_alive),
    .deploy_bird(deploy_bird), .bird_speed(bird_speed), .bird_life(bird_life),
    .level(level), .wave_active(wave_active), .game_won(game_won)
  );

  typedef struct {
    logic [3:0] d;
    int         f;
    int         lvl;
    int         spd;
    int         life;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   sof_cnt = 0;
  int   base;
  int   SPD [4] = '{0, 1, 2, 3};
  int   LIFE[4] = '{2, 4, 6, 8};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input int f, input int lvl);
    exp_t e;
    e.d = d; e.f = f; e.lvl = lvl; e.spd = SPD[lvl]; e.life = LIFE[lvl];
    q.push_back(e);
  endtask

  // A clean wave with zero random jitter and no blocked slots has one pulse every 32 frames after the 120-frame pause.
  task automatic push_wave(input int b, input int lvl);
    push(4'b0001, b + 152, lvl);
    push(4'b0010, b + 184, lvl);
    push(4'b0100, b + 216, lvl);
    push(4'b1000, b + 248, lvl);
  endtask

  // Each frame is 4 clocks. The task enters and exits 1ns after a rising edge.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      sof_cnt++;
      @(posedge clk); #1;
      startOfFrame = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_to(input int target);
    frames(target - sof_cnt);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_deploy"}, deploy_bird, 0);
    chk({tag, "_level"},  level, 0);
    chk({tag, "_speed"},  bird_speed, 0);
    chk({tag, "_life"},   bird_life, 2);
    chk({tag, "_active"}, wave_active, 0);
    chk({tag, "_won"},    game_won, 0);
  endtask

  task automatic monitor();
    logic [3:0] prev;
    exp_t e;
    prev = 4'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 4'b0;
      end else begin
        if (deploy_bird != 4'b0) begin
          chk("pulse_width", prev, 0);
          if (q.size() == 0) begin
            chk("unexpected_pulse", deploy_bird, 0);
          end else begin
            e = q.pop_front();
            chk("pulse_bits",  deploy_bird, e.d);
            chk("pulse_frame", sof_cnt, e.f);
            chk("pulse_level", level, e.lvl);
            chk("pulse_speed", bird_speed, e.spd);
            chk("pulse_life",  bird_life, e.life);
            chk("pulse_active", wave_active, 1);
          end
        end
        prev = deploy_bird;
      end
    end
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; enable = 1'b0;
    random_number = 8'd0; bird_alive = 4'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst0");
    reset = 1'b0;
    @(posedge clk); #1;

    // Wave 0. Slot 2 is held alive for 5 frames when it comes due.
    enable = 1'b1;
    @(posedge clk); #1;
    push(4'b0001, 152, 0);
    push(4'b0010, 184, 0);
    push(4'b0100, 221, 0);
    push(4'b1000, 253, 0);
    run_to(200);
    chk("w0_active", wave_active, 1);
    chk("w0_level", level, 0);
    bird_alive = 4'b0100;
    run_to(220);
    bird_alive = 4'b0000;
    run_to(253);
    bird_alive = 4'b1111;
    run_to(255);
    chk("wc_hold_level", level, 0);
    chk("wc_active", wave_active, 1);
    bird_alive = 4'b0000;
    run_to(256);
    chk("l1_level", level, 1);
    chk("l1_speed", bird_speed, 1);
    chk("l1_life", bird_life, 4);
    chk("l1_pause_active", wave_active, 0);

    // Level 1 with the maximum jitter of 15, so the gap is 47 frames. Enable drops in the middle of a gap.
    random_number = 8'h0F;
    push(4'b0001, 408, 1);
    push(4'b0010, 455, 1);
    run_to(375);
    chk("l1_still_pause", wave_active, 0);
    run_to(376);
    chk("l1_deploy_entry", wave_active, 1);
    run_to(465);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    chk("drop_level", level, 1);
    chk("drop_active", wave_active, 0);
    chk("drop_deploy", deploy_bird, 0);
    random_number = 8'd0;
    frames(20);

    // Re-enabling restarts level 1 from the pause.
    enable = 1'b1;
    @(posedge clk); #1;
    base = sof_cnt;
    push_wave(base, 1);
    run_to(base + 250);
    chk("l2_level", level, 2);
    chk("l2_speed", bird_speed, 2);
    chk("l2_life", bird_life, 6);
    base = sof_cnt;
    push_wave(base, 2);
    run_to(base + 250);
    chk("l3_level", level, 3);
    chk("l3_speed", bird_speed, 3);
    chk("l3_life", bird_life, 8);
    base = sof_cnt;
    push_wave(base, 3);
    run_to(base + 249);
    chk("pre_won", game_won, 0);
    run_to(base + 250);
    chk("won", game_won, 1);
    chk("won_active", wave_active, 0);
    chk("won_level", level, 3);

    // The won state ignores enable toggles.
    enable = 1'b0; frames(5);
    enable = 1'b1; frames(150);
    enable = 1'b0; frames(3);
    enable = 1'b1; frames(130);
    chk("won_sticky", game_won, 1);
    chk("won_active2", wave_active, 0);

    // Leave the won state with a reset, then reset again in the middle of a deploy.
    reset = 1'b1;
    @(posedge clk); #1;
    chk("won_cleared", game_won, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    base = sof_cnt;
    push(4'b0001, base + 152, 0);
    run_to(base + 170);
    reset = 1'b1;
    #2;
    chk_reset_vals("rst_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Start of frame coincides with enable falling exactly when slot 1 is due. Enable wins.
    base = sof_cnt;
    push(4'b0001, base + 152, 0);
    run_to(base + 183);
    enable = 1'b0;
    startOfFrame = 1'b1;
    sof_cnt++;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    chk("coinc_active", wave_active, 0);
    chk("coinc_deploy", deploy_bird, 0);
    frames(40);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
